// File: rtl/code_block_buffer.sv
// Code block buffer: collects one code block (small or large) from a byte stream,
// holds it for the encoder, which pops the bytes show-ahead style, and frees the
// buffer once the encoder reports completion.
//
// Ports:
//   clk                - clock, all state changes on rising edge
//   reset              - asynchronous active-low reset
//   in_data/in_valid   - upstream byte and its valid qualifier
//   in_start           - first byte of a block
//   in_size            - block size at the start byte (0 small, 1 large)
//   in_ready           - buffer accepts a byte this cycle
//   blk_data           - show-ahead byte at the read pointer
//   blk_data_rdreq     - pop request from the encoder
//   blk_empty          - all bytes of the held block popped, or nothing held
//   blk_ready          - one-cycle pulse when a complete block is held
//   tail_byte          - last byte of the held block
//   code_block_length  - size flag of the held block
//   computation_done   - encoder finished with the held block
//   err_restart        - sticky: a block was restarted mid-fill
module code_block_buffer #(
  parameter int unsigned SMALL_BYTES = 132,
  parameter int unsigned LARGE_BYTES = 768
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_start,
  input  logic       in_size,
  output logic       in_ready,
  output logic [7:0] blk_data,
  input  logic       blk_data_rdreq,
  output logic       blk_empty,
  output logic       blk_ready,
  output logic [7:0] tail_byte,
  output logic       code_block_length,
  input  logic       computation_done,
  output logic       err_restart
);

  localparam logic [9:0] SmallN = 10'(SMALL_BYTES);
  localparam logic [9:0] LargeN = 10'(LARGE_BYTES);

  typedef enum logic [1:0] {StIdle, StFill, StHold, StDrain} state_e;

  state_e     state_q;
  logic [9:0] wcnt_q;
  logic [9:0] rptr_q;
  logic       blk_ready_q;
  logic [7:0] tail_q;
  logic       len_q;
  logic       err_q;
  logic [7:0] mem [LARGE_BYTES];

  logic       accept;
  logic       start_acc;
  logic       fill_acc;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [9:0] wcnt_next;
  logic [9:0] n_held;
  logic [9:0] n_fill;
  logic       blk_done;
  logic       pop;

  assign in_ready  = (state_q == StIdle) || (state_q == StFill);
  assign accept    = in_valid && in_ready;
  assign start_acc = accept && in_start;
  // Non-start bytes only count once a block is being filled; in IDLE they are dropped.
  assign fill_acc  = accept && !in_start && (state_q == StFill);
  assign wr_en     = start_acc || fill_acc;
  assign wr_addr   = start_acc ? 10'd0 : wcnt_q;
  assign wcnt_next = wr_addr + 10'd1;

  assign n_held    = len_q ? LargeN : SmallN;
  // A start byte decides the block length itself, before len_q is updated.
  assign n_fill    = start_acc ? (in_size ? LargeN : SmallN) : n_held;
  assign blk_done  = wr_en && (wcnt_next == n_fill);

  assign blk_empty = in_ready ? 1'b1 : (rptr_q == n_held);
  assign pop       = blk_data_rdreq && !blk_empty;
  assign blk_data  = (rptr_q < n_held) ? mem[rptr_q] : 8'h00;

  assign blk_ready         = blk_ready_q;
  assign tail_byte         = tail_q;
  assign code_block_length = len_q;
  assign err_restart       = err_q;

  // Block storage, deliberately without reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      wcnt_q      <= 10'd0;
      rptr_q      <= 10'd0;
      blk_ready_q <= 1'b0;
      tail_q      <= 8'h00;
      len_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      blk_ready_q <= blk_done;
      unique case (state_q)
        StIdle, StFill: begin
          if (wr_en) begin
            wcnt_q <= wcnt_next;
            if (start_acc) begin
              len_q <= in_size;
              if (state_q == StFill) begin
                err_q <= 1'b1;
              end
            end
            if (blk_done) begin
              tail_q  <= in_data;
              rptr_q  <= 10'd0;
              state_q <= StHold;
            end else begin
              state_q <= StFill;
            end
          end
        end
        StHold: begin
          if (pop) begin
            rptr_q  <= rptr_q + 10'd1;
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (computation_done && blk_empty) begin
            wcnt_q  <= 10'd0;
            rptr_q  <= 10'd0;
            state_q <= StIdle;
          end else if (pop) begin
            rptr_q <= rptr_q + 10'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_code_block_buffer.sv
module tb_code_block_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_start;
  logic       in_size;
  logic       in_ready;
  logic [7:0] blk_data;
  logic       blk_data_rdreq;
  logic       blk_empty;
  logic       blk_ready;
  logic [7:0] tail_byte;
  logic       code_block_length;
  logic       computation_done;
  logic       err_restart;

  code_block_buffer dut (
    .clk              (clk),
    .reset            (reset),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_start         (in_start),
    .in_size          (in_size),
    .in_ready         (in_ready),
    .blk_data         (blk_data),
    .blk_data_rdreq   (blk_data_rdreq),
    .blk_empty        (blk_empty),
    .blk_ready        (blk_ready),
    .tail_byte        (tail_byte),
    .code_block_length(code_block_length),
    .computation_done (computation_done),
    .err_restart      (err_restart)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] tail;
    logic       len;
  } blk_t;

  // Scoreboard queues: filled by stimulus, drained by the monitor.
  logic [7:0] exp_data_q[$];
  blk_t       exp_blk_q[$];

  // Behavioural model of the buffer contents.
  logic [7:0] m_cur[$];
  logic [7:0] m_held[$];
  logic       m_size;
  logic       m_filling;
  logic       m_holding;
  logic       m_draining;
  logic       m_err;

  function automatic int nbytes(logic s);
    return s ? 768 : 132;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented output event against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (blk_data_rdreq && !blk_empty) begin
        if (exp_data_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got byte %0h expected no pop", blk_data);
        end else begin
          check("pop_data", {24'd0, blk_data}, {24'd0, exp_data_q.pop_front()});
        end
      end
      if (blk_ready) begin
        if (exp_blk_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL blk_ready_unexpected: got pulse expected none");
        end else begin
          blk_t e;
          e = exp_blk_q.pop_front();
          check("blk_tail", {24'd0, tail_byte}, {24'd0, e.tail});
          check("blk_len", {31'd0, code_block_length}, {31'd0, e.len});
        end
      end
    end
  end

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    in_valid         = 1'b0;
    in_start         = 1'b0;
    blk_data_rdreq   = 1'b0;
    computation_done = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] d, logic st, logic sz);
    if ($urandom_range(0, 3) == 0) idle_cycle();
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_start = st;
    in_size  = st ? sz : 1'($urandom);
    if (!m_holding) begin
      if (st) begin
        if (m_filling) m_err = 1'b1;
        m_cur.delete();
        m_size    = sz;
        m_filling = 1'b1;
        m_cur.push_back(d);
      end else if (m_filling) begin
        m_cur.push_back(d);
      end
      if (m_filling && m_cur.size() == nbytes(m_size)) begin
        exp_blk_q.push_back('{tail: d, len: m_size});
        m_held    = m_cur;
        m_holding = 1'b1;
        m_filling = 1'b0;
      end
    end
  endtask

  task automatic send_block(int n, logic sz, logic rand_data);
    for (int i = 0; i < n; i++) begin
      send_byte(rand_data ? 8'($urandom) : 8'(i), i == 0, sz);
    end
    idle_cycle();
  endtask

  task automatic pop_n(int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      @(posedge clk);
      #1;
      in_valid       = 1'b0;
      blk_data_rdreq = 1'b1;
      if (m_holding && m_held.size() > 0) begin
        exp_data_q.push_back(m_held.pop_front());
        m_draining = 1'b1;
      end
    end
    idle_cycle();
  endtask

  task automatic done_pulse();
    @(posedge clk);
    #1;
    computation_done = 1'b1;
    if (m_draining && m_held.size() == 0) begin
      m_holding  = 1'b0;
      m_draining = 1'b0;
    end
    idle_cycle();
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_blk_empty", {31'd0, blk_empty}, 32'd1);
    check("rst_blk_ready", {31'd0, blk_ready}, 32'd0);
    check("rst_err", {31'd0, err_restart}, 32'd0);
    check("rst_tail", {24'd0, tail_byte}, 32'd0);
    check("rst_len", {31'd0, code_block_length}, 32'd0);
    m_cur.delete();
    m_held.delete();
    m_filling  = 1'b0;
    m_holding  = 1'b0;
    m_draining = 1'b0;
    m_err      = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_held(string tag, logic [7:0] first);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_blk_empty"}, {31'd0, blk_empty}, 32'd0);
    check({tag, "_first"}, {24'd0, blk_data}, {24'd0, first});
  endtask

  initial begin
    logic [7:0] first;
    reset            = 1'b1;
    in_data          = 8'h00;
    in_valid         = 1'b0;
    in_start         = 1'b0;
    in_size          = 1'b0;
    blk_data_rdreq   = 1'b0;
    computation_done = 1'b0;
    m_filling        = 1'b0;
    m_holding        = 1'b0;
    m_draining       = 1'b0;
    m_err            = 1'b0;
    m_size           = 1'b0;
    apply_reset();

    // Stray bytes without start in IDLE are dropped.
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);

    // Small block, bytes 0x00..0x83.
    send_block(132, 1'b0, 1'b0);
    check_held("small", 8'h00);
    done_pulse();  // ignored in HOLD
    check("small_done_hold", {31'd0, in_ready}, {31'd0, !m_holding});
    pop_n(132);
    check("small_empty", {31'd0, blk_empty}, 32'd1);
    pop_n(1);  // extra pop ignored
    check("small_empty2", {31'd0, blk_empty}, 32'd1);
    check("small_in_ready_drain", {31'd0, in_ready}, 32'd0);
    done_pulse();
    check("small_release", {31'd0, in_ready}, {31'd0, !m_holding});

    // Large block with random data.
    send_block(768, 1'b1, 1'b1);
    first = m_held[0];
    check_held("large", first);
    pop_n(768);
    done_pulse();
    check("large_release", {31'd0, in_ready}, 32'd1);

    // Restart at byte 50.
    send_block(50, 1'b0, 1'b1);
    check("err_before", {31'd0, err_restart}, {31'd0, m_err});
    send_block(132, 1'b0, 1'b1);
    check("err_after", {31'd0, err_restart}, {31'd0, m_err});
    check("err_expected_set", {31'd0, err_restart}, 32'd1);

    // Early done after 10 pops is ignored.
    pop_n(10);
    done_pulse();
    check("early_in_ready", {31'd0, in_ready}, 32'd0);
    check("early_empty", {31'd0, blk_empty}, 32'd0);
    pop_n(122);
    done_pulse();
    check("restart_release", {31'd0, in_ready}, 32'd1);

    // Mid-fill reset, then a full block.
    send_block(70, 1'b1, 1'b1);
    apply_reset();
    send_block(132, 1'b0, 1'b1);
    first = m_held[0];
    check_held("post_rst", first);
    check("post_rst_err", {31'd0, err_restart}, 32'd0);
    pop_n(132);
    done_pulse();
    check("post_rst_release", {31'd0, in_ready}, 32'd1);

    repeat (3) idle_cycle();
    check("pending_pops", exp_data_q.size(), 32'd0);
    check("pending_blocks", exp_blk_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code_block_buffer.md
CODE_BLOCK_BUFFER -- requirements
Module: code_block_buffer

Interface
REQ-001 SHALL have parameter SMALL_BYTES, default 132, byte count of a small code block (1056 bits).
REQ-002 SHALL have parameter LARGE_BYTES, default 768, byte count of a large code block (6144 bits).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  8  upstream block byte; bit 0 is the earliest bit in time.
REQ-006 SHALL have port in_valid  input  1  in_data valid this cycle.
REQ-007 SHALL have port in_start  input  1  qualifies in_data as the first byte of a block.
REQ-008 SHALL have port in_size  input  1  block size at the start byte: 0 = small, 1 = large.
REQ-009 SHALL have port in_ready  output  1  buffer accepts a byte this cycle.
REQ-010 SHALL have port blk_data  output  8  show-ahead byte at the read pointer.
REQ-011 SHALL have port blk_data_rdreq  input  1  pop request from the encoder.
REQ-012 SHALL have port blk_empty  output  1  all bytes of the current block have been popped, or no block is held.
REQ-013 SHALL have port blk_ready  output  1  single-cycle pulse when a complete block is held.
REQ-014 SHALL have port tail_byte  output  8  last byte of the held block.
REQ-015 SHALL have port code_block_length  output  1  latched in_size of the held block.
REQ-016 SHALL have port computation_done  input  1  encoder has finished the held block.
REQ-017 SHALL have port err_restart  output  1  sticky flag: a block was restarted mid-fill.

Function
REQ-018 SHALL implement states IDLE, FILL, HOLD and DRAIN, with N = LARGE_BYTES if code_block_length else SMALL_BYTES.
REQ-019 SHALL provide storage of LARGE_BYTES x 8, a write count wcnt[9:0] and a read pointer rptr[9:0].
REQ-020 SHALL drive in_ready = 1 in IDLE and FILL only; a byte is accepted when in_valid && in_ready.
REQ-021 IDLE: an accepted byte with in_start=0 SHALL be dropped with no state change.
REQ-022 IDLE: an accepted byte with in_start=1 SHALL do all of: latch code_block_length <= in_size; write mem[0]; set wcnt=1; go to FILL.
REQ-023 FILL: each accepted byte with in_start=0 SHALL be written to mem[wcnt], then wcnt increments.
REQ-024 FILL: an accepted byte with in_start=1 SHALL discard the partial block and be handled as in REQ-022, and SHALL set err_restart=1.
REQ-025 When the byte accepted brings wcnt to N, the buffer SHALL do all of: latch tail_byte <= in_data; set rptr=0; go to HOLD; assert blk_ready for exactly the next cycle.
REQ-026 code_block_length and tail_byte SHALL be held stable from HOLD entry until return to IDLE.
REQ-027 blk_data SHALL equal mem[rptr] combinationally (show-ahead) whenever rptr < N.
REQ-028 blk_empty SHALL be 1 in IDLE and FILL, and SHALL equal (rptr == N) in HOLD and DRAIN.
REQ-029 blk_data_rdreq with blk_empty=0 SHALL increment rptr, and blk_data SHALL show the new byte in the next cycle.
REQ-030 blk_data_rdreq with blk_empty=1 SHALL be ignored.
REQ-031 HOLD SHALL go to DRAIN on the first accepted pop.
REQ-032 DRAIN SHALL go to IDLE on the cycle where computation_done=1 and blk_empty=1; wcnt and rptr SHALL clear to 0.
REQ-033 computation_done=1 while blk_empty=0 SHALL be ignored.
REQ-034 computation_done=1 in IDLE, FILL or HOLD SHALL be ignored.
REQ-035 The buffer SHALL accept no new block while a block is held (backpressure through in_ready=0).

Reset
REQ-036 reset=0 SHALL asynchronously force: state IDLE; wcnt=0; rptr=0; blk_ready=0; tail_byte=8'h00; code_block_length=0; err_restart=0.
REQ-037 During reset, in_ready SHALL be 1 and blk_empty SHALL be 1.
REQ-038 Memory contents need not be reset.
REQ-039 Reset asserted in any state SHALL discard the block in progress, and operation SHALL resume from IDLE on the first clock after release.

Verification
REQ-040 Small block: 132 bytes 0x00..0x83, start on the first, in_size=0 -> exactly one blk_ready pulse the cycle after byte 131, tail_byte=0x83, code_block_length=0, blk_data=0x00, in_ready=0.
REQ-041 Drain small block: 132 pops -> blk_data reads 0x00..0x83 in order; blk_empty=1 after the 132nd pop; a 133rd pop leaves rptr=132.
REQ-042 Large block: 768 bytes, in_size=1 -> blk_ready after byte 767 only; tail_byte = byte 767; computation_done with blk_empty=1 -> IDLE next cycle, in_ready=1.
REQ-043 Restart: in_start asserted at byte 50 of a small block, then 132 bytes total -> err_restart=1; tail_byte = last byte of the restarted block; blk_ready pulses once.
REQ-044 Early done: computation_done=1 after 10 pops -> state stays DRAIN, in_ready stays 0.
REQ-045 Mid-fill reset: reset=0 at byte 70 -> in_ready=1, blk_empty=1, no blk_ready; a following full block is buffered correctly.
